// File: rtl/bk_adder_arbiter.sv
// Round-robin arbiter sharing one external combinational Brent-Kung adder among
// NUM_REQ requesters. Optional signed-overflow output enabled by BK_ARB_OVF_FLAG_EN.
module bk_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic [DATA_W-1:0]         adder_a,
  output logic [DATA_W-1:0]         adder_b,
  output logic                      adder_cin,
  input  logic [DATA_W-1:0]         adder_sum,
  input  logic                      adder_cout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_sum,
  output logic                      res_cout,
  output logic [ID_W-1:0]           res_id,
  output logic [15:0]               op_count
`ifdef BK_ARB_OVF_FLAG_EN
  ,
  output logic                      res_ovf
`endif
);

  localparam int MSB = DATA_W - 1;

  logic              can_accept;
  logic              grant;
  logic [ID_W-1:0]   win;
  logic [ID_W:0]     idx;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_sum_q;
  logic              res_cout_q;
  logic [ID_W-1:0]   res_id_q;
  logic [15:0]       op_count_q;

  // A full result register drained this cycle can take a new result at once.
  assign can_accept = !res_valid_q || res_ready;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!grant && req_valid[idx[ID_W-1:0]]) begin
        grant = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
    // Arbitration is suppressed while reset is held so req_ready reads zero.
    if (!can_accept || rst) grant = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (grant) begin
      req_ready[win] = 1'b1;
      adder_a        = req_a[win*DATA_W +: DATA_W];
      adder_b        = req_b[win*DATA_W +: DATA_W];
      adder_cin      = req_cin[win];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    res_valid_d = res_valid_q;
    if (grant)          res_valid_d = 1'b1;
    else if (res_ready) res_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      if (grant) begin
        res_sum_q  <= adder_sum;
        res_cout_q <= adder_cout;
        res_id_q   <= win;
      end
      if (res_valid_q && res_ready) op_count_q <= op_count_q + 16'd1;
    end
  end

`ifdef BK_ARB_OVF_FLAG_EN
  logic ovf_d, res_ovf_q;

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_d = (adder_a[MSB] == adder_b[MSB]) && (adder_sum[MSB] != adder_a[MSB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        res_ovf_q <= 1'b0;
    else if (grant) res_ovf_q <= ovf_d;
  end

  assign res_ovf = res_ovf_q;
`endif

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Scoreboard bench for bk_adder_arbiter: directed vectors push expected results,
// a negedge monitor pops and compares on each result handshake.
module tb_bk_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic [1:0]  id;
    logic        ovf;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]        req_cin;
  logic [DATA_W-1:0]         adder_a, adder_b, adder_sum;
  logic                      adder_cin, adder_cout;
  logic                      res_valid, res_ready, res_cout;
  logic [DATA_W-1:0]         res_sum;
  logic [ID_W-1:0]           res_id;
  logic [15:0]               op_count;
`ifdef BK_ARB_OVF_FLAG_EN
  logic                      res_ovf;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  bk_adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .op_count   (op_count)
`ifdef BK_ARB_OVF_FLAG_EN
    ,
    .res_ovf    (res_ovf)
`endif
  );

  // Behavioural stand-in for the external combinational adder.
  assign {adder_cout, adder_sum} = 17'(adder_a) + 17'(adder_b) + 17'(adder_cin);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
    req_cin[i]                = c;
  endtask

  task automatic push(input logic [15:0] s, input logic c, input logic [1:0] id, input logic v);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.id   = id;
    e.ovf  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: the handshake completes at the next posedge, so compare now.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 32'(res_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_sum",  32'(res_sum),  32'(mon_e.sum));
        check("res_cout", 32'(res_cout), 32'(mon_e.cout));
        check("res_id",   32'(res_id),   32'(mon_e.id));
`ifdef BK_ARB_OVF_FLAG_EN
        check("res_ovf",  32'(res_ovf),  32'(mon_e.ovf));
`endif
      end
    end
  end

  logic [15:0] fair_sum [4];
  logic [3:0]  oh;

  initial begin
    fair_sum[0] = 16'h1010;
    fair_sum[1] = 16'h2020;
    fair_sum[2] = 16'h3030;
    fair_sum[3] = 16'h4040;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b0;

    #12;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum",   32'(res_sum),   32'd0);
    check("rst_res_cout",  32'(res_cout),  32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Basic add from requester 0, result held until the consumer is ready.
    set_req(0, 16'h1234, 16'h0FF0, 1'b0);
    req_valid = 4'b0001;
    #1 check("t1_req_ready", 32'(req_ready), 32'b0001);
    push(16'h2224, 1'b0, 2'd0, 1'b0);
    tick();
    req_valid = '0;
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_op_count0", 32'(op_count), 32'd0);
    res_ready = 1'b1;
    tick();
    check("t1_op_count1", 32'(op_count), 32'd1);
    check("t1_drained",   32'(res_valid), 32'd0);

    // Carry-out from requester 2 (pointer is 1, search reaches 2).
    set_req(2, 16'hFFFF, 16'h0001, 1'b1);
    req_valid = 4'b0100;
    #1 check("t2_req_ready", 32'(req_ready), 32'b0100);
    push(16'h0001, 1'b1, 2'd2, 1'b0);
    tick();
    req_valid = '0;
    tick();
    check("t2_op_count", 32'(op_count), 32'd2);

    // Requester 3: 0x8000+0x8000 wraps to zero with carry, pointer returns to 0.
    set_req(3, 16'h8000, 16'h8000, 1'b0);
    req_valid = 4'b1000;
    #1 check("t3_req_ready", 32'(req_ready), 32'b1000);
    push(16'h0000, 1'b1, 2'd3, 1'b1);
    tick();
    req_valid = '0;
    tick();
    check("t3_op_count", 32'(op_count), 32'd3);

    // Fairness: all requesters valid, grants rotate 0,1,2,3 at one per cycle.
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 16'(16'h1000 * (i + 1)), 16'(16'h0010 * (i + 1)), 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      oh = 4'b0001 << (k % 4);
      #1 check("fair_req_ready", 32'(req_ready), 32'(oh));
      push(fair_sum[k % 4], 1'b0, 2'(k % 4), 1'b0);
      tick();
    end
    check("fair_op_count", 32'(op_count), 32'd10);

    // Backpressure: result from requester 3 held, no grants, pointer frozen.
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_sum",   32'(res_sum),   32'h4040);
      check("bp_res_id",    32'(res_id),    32'd3);
      tick();
    end
    res_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b0001);
    push(16'h1010, 1'b0, 2'd0, 1'b0);
    tick();
    check("bp_op_count", 32'(op_count), 32'd11);

    // Async reset between edges discards the in-flight result.
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_op_count",  32'(op_count),  32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_res_sum",   32'(res_sum),   32'd0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1 check("arst_first_grant", 32'(req_ready), 32'b0001);
    push(16'h1010, 1'b0, 2'd0, 1'b0);
    tick();
    req_valid = '0;
    tick();
    check("arst_op_count1", 32'(op_count), 32'd1);

    // Signed-overflow vectors from requester 1; the second wraps the search.
    set_req(1, 16'h7FFF, 16'h0001, 1'b0);
    req_valid = 4'b0010;
    #1 check("ovf1_req_ready", 32'(req_ready), 32'b0010);
    push(16'h8000, 1'b0, 2'd1, 1'b1);
    tick();
    req_valid = '0;
    tick();
    set_req(1, 16'h8000, 16'hFFFF, 1'b0);
    req_valid = 4'b0010;
    #1 check("ovf2_req_ready", 32'(req_ready), 32'b0010);
    push(16'h7FFF, 1'b1, 2'd1, 1'b1);
    tick();
    req_valid = '0;
    tick();
    check("ovf_op_count", 32'(op_count), 32'd3);

    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
